spi_tx: RTL

- SPI-style serial transmitter: the controller end of the same DCLK/data link that the team's 8-bit SPI receiver decodes.
- Accepts a parallel word over a valid/ready handshake, frames it with an active-low chip select, generates DCLK, and shifts data out MSB first.
- Data is stable across every DCLK falling edge, which is where the receiver samples.
- Sits in sys_io next to the receiver; its outputs go to FPGA pins or loop back to a receiver instance in test.

---
 rtl/spi_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spi_tx.sv
// SPI controller transmitter: frames each word with an active-low chip select and shifts it MSB first on DCLK.
// Define SPI_TX_BURST_EN to let back-to-back words stream under one chip select.
module spi_tx #(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_CLK_PERIOD = 100
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  done_out,
    output logic                  chip_sel_out,
    output logic                  chip_clk_out,
    output logic                  chip_data_out
);

    localparam int H  = DATA_CLK_PERIOD / 2;
    localparam int HW = $clog2(H) + 1;
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]            state;
    logic [HW-1:0]         hcnt;
    logic [BW-1:0]         bitcnt;
    logic                  phase_hi;
    logic [DATA_WIDTH-1:0] sreg;
    logic                  hcnt_last;
    logic                  bit_last;
    logic                  accept;

    assign hcnt_last = (hcnt == HW'(H - 1));
    assign bit_last  = (bitcnt == BW'(DATA_WIDTH - 1));

`ifdef SPI_TX_BURST_EN
    // Also ready in the final low cycle of the last bit so the next word follows without a gap.
    assign ready_out = (state == S_IDLE) ||
                       (state == S_SHIFT && !phase_hi && bit_last && hcnt_last);
`else
    assign ready_out = (state == S_IDLE);
`endif

    assign accept = valid_in && ready_out;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state         <= S_IDLE;
            hcnt          <= '0;
            bitcnt        <= '0;
            phase_hi      <= 1'b0;
            sreg          <= '0;
            done_out      <= 1'b0;
            chip_sel_out  <= 1'b1;
            chip_clk_out  <= 1'b0;
            chip_data_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    hcnt <= '0;
                    if (accept) begin
                        sreg          <= data_in;
                        chip_sel_out  <= 1'b0;
                        chip_data_out <= data_in[DATA_WIDTH-1];
                        state         <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (hcnt_last) begin
                        hcnt          <= '0;
                        bitcnt        <= '0;
                        phase_hi      <= 1'b1;
                        chip_clk_out  <= 1'b1;
                        chip_data_out <= sreg[DATA_WIDTH-1];
                        sreg          <= sreg << 1;
                        state         <= S_SHIFT;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!hcnt_last) begin
                        hcnt <= hcnt + 1'b1;
                    end else begin
                        hcnt <= '0;
                        if (phase_hi) begin
                            phase_hi     <= 1'b0;
                            chip_clk_out <= 1'b0;
                        end else if (!bit_last) begin
                            bitcnt        <= bitcnt + 1'b1;
                            phase_hi      <= 1'b1;
                            chip_clk_out  <= 1'b1;
                            chip_data_out <= sreg[DATA_WIDTH-1];
                            sreg          <= sreg << 1;
                        end else if (accept) begin
                            // Burst continuation: new word's MSB goes out on this rising edge.
                            bitcnt        <= '0;
                            phase_hi      <= 1'b1;
                            chip_clk_out  <= 1'b1;
                            chip_data_out <= data_in[DATA_WIDTH-1];
                            sreg          <= data_in << 1;
                            done_out      <= 1'b1;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (hcnt_last) begin
                        hcnt         <= '0;
                        chip_sel_out <= 1'b1;
                        done_out     <= 1'b1;
                        state        <= S_GAP;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (hcnt_last) begin
                        hcnt  <= '0;
                        state <= S_IDLE;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    hcnt  <= '0;
                end
            endcase
        end
    end

endmodule
